// File: rtl/testing_wb_slave.sv
// Wishbone B3 test responder: DEPTH-word register bank with byte-lane writes,
// programmable wait states, linear incrementing bursts and out-of-range errors.
module testing_wb_slave #(
    parameter int unsigned   dw          = 32,
    parameter int unsigned   aw          = 32,
    parameter logic [aw-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned   DEPTH       = 16,
    parameter int unsigned   WAIT_STATES = 1
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    input  logic          hold,
    output logic          active
);

    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [aw-1:0] SPAN     = aw'(4 * DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [3:0]    WS_INIT  = 4'(WAIT_STATES);
    localparam logic [2:0]    CTI_INC  = 3'b010;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ACK   = 3'd2;
    localparam logic [2:0] S_BURST = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [dw-1:0] mem_q [DEPTH];
    logic [dw-1:0] mem_d [DEPTH];

    logic          req;
    logic          hit;
    logic          last;
    logic          inc_burst;
    logic          wr_en;
    logic [aw-1:0] offset;

    always_comb begin
        req       = wb_cyc_i & wb_stb_i;
        offset    = wb_adr_i - BASE_ADDR;
        hit       = (wb_adr_i >= BASE_ADDR) && (offset < SPAN);
        last      = (ptr_q == PTR_LAST);
        inc_burst = (wb_cti_i == CTI_INC);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = WS_INIT;
                    ptr_d   = offset[PW+1:2];
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (!hit || (inc_burst && (wb_bte_i != 2'b00))) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                wr_en = req & wb_we_i;
                if (req && inc_burst && !hold) begin
                    if (last) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_BURST;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    wr_en = wb_we_i;
                    if (!inc_burst) begin
                        state_d = S_IDLE;
                    end else if (last) begin
                        state_d = S_ERR;
                    end else begin
                        // The acked beat has completed; a hold parks at the next word.
                        ptr_d = ptr_q + 1'b1;
                        if (hold) begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_BURST;
                        end
                    end
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ack_d = (state_d == S_ACK) || (state_d == S_BURST);
        err_d = (state_d == S_ERR);
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem_d[ptr_q][8*b +: 8] = wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        wb_ack_o = ack_q;
        wb_err_o = err_q;
        wb_rty_o = 1'b0;
        wb_dat_o = ack_q ? mem_q[ptr_q] : '0;
        active   = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_testing_wb_slave.sv
// Self-checking bench for testing_wb_slave: constant vector table, directed
// multi-cycle sequences, and random transactions against a word-array model.
module tb_testing_wb_slave;

    localparam int          DEPTH = 16;
    localparam int          WS    = 1;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        hold;
    logic        active;

    always #5 wb_clk = ~wb_clk;

    testing_wb_slave #(
        .dw(32), .aw(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(WS)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .hold(hold), .active(active)
    );

    typedef struct {
        bit          wr;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] wbuf  [8];

    int          ack_slot [$];
    logic [31:0] ack_data [$];
    int          err_slot;
    int          err_seen;
    bit          both_seen;
    bit          timed_out;
    logic        post_ack, post_err, post_active;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [2:0] beat_cti(input int k, input int n);
        if (n == 1) return 3'b000;
        if (k == n - 1) return 3'b111;
        return 3'b010;
    endfunction

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic drive_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0;
        wb_dat_i = '0;   wb_sel_i = '0;   wb_cti_i = '0;  hold = 1'b0;
    endtask

    task automatic drive_beat(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] c);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = wr; wb_adr_i = a;
        wb_dat_i = d;    wb_sel_i = s;    wb_cti_i = c;
    endtask

    // Master: n==1 is a classic cycle, n>1 a linear burst ending in cti 111.
    // ch = hold cycles during the initial wait; hb/hl = hold after the ack of beat hb.
    task automatic bus_xfer(input bit wr, input logic [31:0] start, input int n,
                            input logic [3:0] s, input int ch, input int hb, input int hl);
        int k, slot, hold_rem;
        bit last_ack, done;
        k = 0; slot = 0; hold_rem = 0; last_ack = 0; done = 0;
        ack_slot.delete(); ack_data.delete();
        err_slot = -1; err_seen = 0; both_seen = 0; timed_out = 0;
        drive_beat(wr, start, wbuf[0], s, beat_cti(0, n));
        while (!done) begin
            tick();
            slot++;
            if (last_ack) begin
                k++;
                last_ack = 0;
                if (k < n) drive_beat(wr, start + 32'(4 * k), wbuf[k], s, beat_cti(k, n));
            end
            if (wb_ack_o && wb_err_o) both_seen = 1;
            if (wb_ack_o) begin
                ack_slot.push_back(slot);
                ack_data.push_back(wb_dat_o);
                last_ack = 1;
                if (k == hb) hold_rem = hl;
                if (k == n - 1) done = 1;
            end
            if (wb_err_o) begin
                err_seen++;
                err_slot = slot;
                done = 1;
            end
            if (slot >= 200) begin
                timed_out = 1;
                done = 1;
            end
            if (n == 1) begin
                hold = (slot >= 1) && (slot <= ch);
            end else begin
                hold = (hold_rem > 0);
                if (hold_rem > 0) hold_rem--;
            end
        end
        tick();
        post_ack = wb_ack_o; post_err = wb_err_o; post_active = active;
        drive_idle();
    endtask

    task automatic run_and_check(input bit wr, input logic [31:0] start, input int n,
                                 input logic [3:0] s, input int ch, input int hb, input int hl);
        bit hit, exp_err;
        int word, nack, exp_slot;
        bus_xfer(wr, start, n, s, ch, hb, hl);
        hit  = (start >= BASE) && (start < BASE + 32'(4 * DEPTH));
        word = int'((start - BASE) >> 2);
        if (!hit) begin
            nack = 0;
            exp_err = 1;
        end else begin
            exp_err = (word + n > DEPTH);
            nack    = exp_err ? DEPTH - word : n;
        end
        check("xfer_timeout", timed_out, 0);
        check("ack_count", ack_slot.size(), nack);
        exp_slot = WS + 2 + ((n == 1) ? ch : 0);
        for (int k = 0; k < nack && k < ack_slot.size(); k++) begin
            check($sformatf("ack_slot_beat%0d", k), ack_slot[k], exp_slot);
            if (!wr) check($sformatf("rd_data_beat%0d", k), ack_data[k], model[word + k]);
            if (wr) model[word + k] = merge(model[word + k], wbuf[k], s);
            exp_slot += 1 + ((k == hb) ? hl : 0);
        end
        check("err_count", err_seen, exp_err ? 1 : 0);
        if (exp_err) check("err_slot", err_slot, exp_slot);
        check("ack_err_overlap", both_seen, 0);
        check("post_ack", post_ack, 0);
        check("post_err", post_err, 0);
        check("post_active", post_active, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [13];
        logic [31:0] st;
        int          n, ch, hb, hl, first;
        bit          wr;
        logic [3:0]  s;

        tbl[0]  = '{1, 32'h08, 32'hDEADBEEF, 4'b1111, 0, 32'h0};
        tbl[1]  = '{0, 32'h08, 32'h0,        4'b1111, 0, 32'hDEADBEEF};
        tbl[2]  = '{1, 32'h04, 32'h11223344, 4'b1111, 0, 32'h0};
        tbl[3]  = '{1, 32'h04, 32'hAABBCCDD, 4'b0101, 0, 32'h0};
        tbl[4]  = '{0, 32'h04, 32'h0,        4'b1111, 0, 32'h11BB33DD};
        tbl[5]  = '{0, 32'h40, 32'h0,        4'b1111, 1, 32'h0};
        tbl[6]  = '{1, 32'h44, 32'h12345678, 4'b1111, 1, 32'h0};
        tbl[7]  = '{0, 32'h00, 32'h0,        4'b1111, 0, 32'h0};
        tbl[8]  = '{1, 32'h3C, 32'h5A5A5A5A, 4'b1000, 0, 32'h0};
        tbl[9]  = '{0, 32'h3C, 32'h0,        4'b1111, 0, 32'h5A000000};
        tbl[10] = '{1, 32'h3C, 32'hFFFFFFFF, 4'b0000, 0, 32'h0};
        tbl[11] = '{0, 32'h3C, 32'h0,        4'b1111, 0, 32'h5A000000};
        tbl[12] = '{0, 32'hFFFFFFFC, 32'h0,  4'b1111, 1, 32'h0};

        wb_bte_i = 2'b00;
        wb_rst_n = 1'b0;
        drive_idle();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick(); tick(); tick();
        check("rst_ack", wb_ack_o, 0);
        check("rst_err", wb_err_o, 0);
        check("rst_rty", wb_rty_o, 0);
        check("rst_active", active, 0);
        check("rst_dat", wb_dat_o, 0);
        wb_rst_n = 1'b1;
        tick();

        // Classic single cycles from the constant table.
        for (int i = 0; i < 13; i++) begin
            wbuf[0] = tbl[i].dat;
            bus_xfer(tbl[i].wr, tbl[i].adr, 1, tbl[i].sel, 0, -1, 0);
            check($sformatf("tbl%0d_ack", i), ack_slot.size(), tbl[i].exp_err ? 0 : 1);
            check($sformatf("tbl%0d_err", i), err_seen, tbl[i].exp_err ? 1 : 0);
            first = tbl[i].exp_err ? err_slot : ((ack_slot.size() > 0) ? ack_slot[0] : -1);
            check($sformatf("tbl%0d_latency", i), first, WS + 2);
            if (!tbl[i].wr && !tbl[i].exp_err && ack_data.size() > 0)
                check($sformatf("tbl%0d_rdata", i), ack_data[0], tbl[i].exp_rd);
            check($sformatf("tbl%0d_post_ack", i), post_ack, 0);
            if (tbl[i].wr && !tbl[i].exp_err) begin
                st = (tbl[i].adr - BASE) >> 2;
                model[st] = merge(model[st], tbl[i].dat, tbl[i].sel);
            end
            tick();
        end

        // Four-beat write then read burst from word 0.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        run_and_check(1, 32'h00, 4, 4'b1111, 0, -1, 0);
        run_and_check(0, 32'h00, 4, 4'b1111, 0, -1, 0);
        for (int i = 0; i < 4 && i < ack_data.size(); i++)
            check($sformatf("burst4_const_beat%0d", i), ack_data[i], 32'(i + 1));

        // Burst continuing past the top word: last word acked, then one err.
        run_and_check(0, 32'h3C, 2, 4'b1111, 0, -1, 0);
        run_and_check(0, 32'h3C, 1, 4'b1111, 0, -1, 0);

        // Hold during a classic read delays the ack by the hold length.
        run_and_check(0, 32'h00, 1, 4'b1111, 3, -1, 0);
        if (ack_slot.size() > 0) check("hold3_latency", ack_slot[0], WS + 2 + 3);

        // Holds in the middle of bursts.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
        run_and_check(1, 32'h10, 4, 4'b1111, 0, 1, 2);
        run_and_check(0, 32'h10, 4, 4'b1111, 0, 2, 3);

        // Unsupported burst type errors before any ack.
        wb_bte_i = 2'b01;
        bus_xfer(0, 32'h00, 2, 4'b1111, 0, -1, 0);
        wb_bte_i = 2'b00;
        check("bte_acks", ack_slot.size(), 0);
        check("bte_err", err_seen, 1);
        check("bte_err_slot", err_slot, WS + 2);

        // Cycle dropped while waiting: no response, no write.
        drive_beat(1, 32'h08, 32'h0BADF00D, 4'b1111, 3'b000);
        tick();
        check("drop_active_wait", active, 1);
        drive_idle();
        tick();
        check("drop_ack", wb_ack_o, 0);
        check("drop_err", wb_err_o, 0);
        check("drop_active", active, 0);
        tick();
        check("drop_ack2", wb_ack_o, 0);
        run_and_check(0, 32'h08, 1, 4'b1111, 0, -1, 0);

        // Reset during a write burst: no completion and the bank is cleared.
        drive_beat(1, 32'h20, 32'hCAFE0000, 4'b1111, 3'b010);
        tick(); tick(); tick();
        check("rstb_first_ack", wb_ack_o, 1);
        wb_rst_n = 1'b0;
        tick();
        check("rstb_ack", wb_ack_o, 0);
        check("rstb_err", wb_err_o, 0);
        check("rstb_active", active, 0);
        check("rstb_dat", wb_dat_o, 0);
        wb_rst_n = 1'b1;
        drive_idle();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick();
        run_and_check(0, 32'h20, 1, 4'b1111, 0, -1, 0);
        run_and_check(0, 32'h08, 1, 4'b1111, 0, -1, 0);

        // Random classic and burst transactions.
        for (int t = 0; t < 40; t++) begin
            st = BASE + 32'(4 * $urandom_range(0, 19));
            n  = $urandom_range(1, 4);
            wr = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            ch = 0; hb = -1; hl = 0;
            for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
            if (n == 1) begin
                ch = $urandom_range(0, 2);
            end else if (n >= 3 && (int'((st - BASE) >> 2) + n <= DEPTH) && ($urandom_range(0, 1) == 1)) begin
                hb = $urandom_range(1, n - 2);
                hl = $urandom_range(1, 3);
            end
            run_and_check(wr, st, n, s, ch, hb, hl);
        end

        check("final_rty", wb_rty_o, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
